trigger_capture: RTL and testbench
==================================

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 Parameter AUTO_TIMEOUT, default 16'd50000: number of accepted samples in WAIT_TRIG before auto mode forces a trigger.
REQ-002 clock  input  1  sole clock; all logic on posedge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 adc_data  input  8  ADC sample, unsigned.
REQ-005 adc_valid  input  1  adc_data is valid this cycle (one-cycle strobe per sample).
REQ-006 sample_type  input  1  1 = double frame (400 points); 0 = single frame (200 points).
REQ-007 trig_level  input  8  trigger threshold, unsigned.
REQ-008 trig_slope  input  1  1 = rising edge; 0 = falling edge.
REQ-009 trig_auto  input  1  1 = auto mode (timeout forces trigger); 0 = normal mode.
REQ-010 arm  input  1  request a capture; honoured only in IDLE.
REQ-011 abort  input  1  cancel the capture in progress.
REQ-012 ram_wr_en  output  1  RAM write strobe.
REQ-013 ram_wr_addr  output  9  RAM write address.
REQ-014 ram_wr_data  output  8  RAM write data.
REQ-015 frame_done  output  1  one-cycle pulse when a full frame has been written.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 auto_trig  output  1  high from the trigger cycle until the next arm if the current frame was started by timeout.

Function
REQ-018 States: IDLE, WAIT_TRIG, CAPTURE, DONE; all outputs registered.
REQ-019 IDLE: arm=1 -> WAIT_TRIG next cycle; latch frame length N (400 if sample_type=1, else 200), clear prev_valid, clear timeout counter, clear auto_trig.
REQ-020 sample_type changes after arm SHALL NOT affect N for the current frame.
REQ-021 WAIT_TRIG, each adc_valid: store adc_data as prev and set prev_valid; no edge is evaluated on the first valid sample after arming.
REQ-022 Rising trigger: prev_valid and prev < trig_level and adc_data >= trig_level. Falling trigger: prev_valid and prev > trig_level and adc_data <= trig_level.
REQ-023 Auto trigger: trig_auto=1 and adc_valid and timeout counter = AUTO_TIMEOUT-1; set auto_trig. An edge trigger in the same cycle takes precedence and auto_trig stays 0.
REQ-024 Timeout counter: 16 bits, increments on each adc_valid in WAIT_TRIG, saturates; it has no effect when trig_auto=0.
REQ-025 Trigger cycle: the triggering sample is written at address 0 (ram_wr_en=1, ram_wr_addr=0, ram_wr_data=adc_data, one cycle after the trigger edge); state -> CAPTURE.
REQ-026 CAPTURE: each adc_valid writes adc_data at the next address (1,2,...,N-1), one-cycle write latency; cycles without adc_valid produce no write.
REQ-027 Write to address N-1 -> DONE; the address SHALL NOT wrap or exceed N-1 within a frame.
REQ-028 DONE: frame_done=1 for exactly one cycle, then IDLE; arm asserted during DONE is ignored.
REQ-029 arm asserted in WAIT_TRIG, CAPTURE or DONE SHALL be ignored.
REQ-030 abort=1 in any state: IDLE next cycle, no write that cycle, no frame_done; abort takes precedence over arm, trigger and the final write.
REQ-031 ram_wr_en is low in IDLE, WAIT_TRIG and DONE except for the trigger-cycle write.
REQ-032 When not writing, ram_wr_addr holds its last value and ram_wr_data holds its last value.

Reset
REQ-033 rst_n=0 at posedge: state IDLE; ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, frame_done=0, busy=0, auto_trig=0; prev_valid=0; counters 0.
REQ-034 Reset mid-capture SHALL discard the frame, with no frame_done and no further writes.

Verification
REQ-035 sample_type=0, rising, level=128, ramp 100,120,140,... on every cycle, then arm -> sample 140 written at addr 0; 200 writes total at addr 0..199; one frame_done pulse; busy drops.
REQ-036 sample_type=1, falling, level=50, data 60 then 40 -> 40 written at addr 0; 400 writes; last addr 399; no address wrap.
REQ-037 trig_auto=1, AUTO_TIMEOUT=16, constant data 10 -> trigger on the 16th valid sample after arm; auto_trig=1; full frame written.
REQ-038 trig_auto=0, constant data -> stays in WAIT_TRIG indefinitely with no writes; abort -> IDLE next cycle with busy=0.
REQ-039 adc_valid every 3rd cycle during CAPTURE -> writes only on valid cycles, addresses contiguous; arm pulses mid-capture are ignored.
REQ-040 rst_n=0 at address 57 of a frame -> all outputs at reset values the next cycle; no frame_done; a new arm starts again at address 0.

Source files
------------

// File: rtl/trigger_capture.sv
// trigger_capture: oscilloscope-style trigger and frame capture into a RAM.
//
// Waits for an edge crossing of trig_level on the ADC stream, or a timeout in
// auto mode. It then writes a frame of N samples (200 or 400) to RAM addresses
// 0..N-1 and pulses frame_done once the frame is complete.
//
// Ports
//   clock        sole clock, posedge
//   rst_n        synchronous active-low reset
//   adc_data     8-bit unsigned ADC sample, qualified by adc_valid
//   adc_valid    one-cycle strobe per sample
//   sample_type  1 = 400-point frame, 0 = 200-point frame (latched on arm)
//   trig_level   trigger threshold
//   trig_slope   1 = rising, 0 = falling
//   trig_auto    1 = timeout after AUTO_TIMEOUT samples forces a trigger
//   arm          start a capture (honoured only in IDLE)
//   abort        cancel the capture; back to IDLE next cycle
//   ram_wr_en    RAM write strobe
//   ram_wr_addr  RAM write address
//   ram_wr_data  RAM write data
//   frame_done   one-cycle pulse after the last sample of a frame is written
//   busy         high whenever not IDLE
//   auto_trig    frame was started by timeout (held until the next arm)
module trigger_capture #(
  parameter logic [15:0] AUTO_TIMEOUT = 16'd50000
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [7:0] adc_data,
  input  logic       adc_valid,
  input  logic       sample_type,
  input  logic [7:0] trig_level,
  input  logic       trig_slope,
  input  logic       trig_auto,
  input  logic       arm,
  input  logic       abort,
  output logic       ram_wr_en,
  output logic [8:0] ram_wr_addr,
  output logic [7:0] ram_wr_data,
  output logic       frame_done,
  output logic       busy,
  output logic       auto_trig
);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

  state_t      state;
  logic [8:0]  last_addr;
  logic [7:0]  prev;
  logic        prev_valid;
  logic [15:0] timeout_cnt;
  logic        edge_hit;
  logic        timeout_hit;

  always_comb begin
    edge_hit = 1'b0;
    if (prev_valid) begin
      if (trig_slope)
        edge_hit = (prev < trig_level) && (adc_data >= trig_level);
      else
        edge_hit = (prev > trig_level) && (adc_data <= trig_level);
    end
    timeout_hit = trig_auto && (timeout_cnt == AUTO_TIMEOUT - 16'd1);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state       <= IDLE;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      auto_trig   <= 1'b0;
      last_addr   <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      ram_wr_en  <= 1'b0;
      frame_done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              state       <= WAIT_TRIG;
              busy        <= 1'b1;
              last_addr   <= sample_type ? 9'd399 : 9'd199;
              prev_valid  <= 1'b0;
              timeout_cnt <= '0;
              auto_trig   <= 1'b0;
            end
          end
          WAIT_TRIG: begin
            if (adc_valid) begin
              prev       <= adc_data;
              prev_valid <= 1'b1;
              if (timeout_cnt != '1)
                timeout_cnt <= timeout_cnt + 16'd1;
              // An edge in the same cycle as the timeout wins, so auto_trig
              // only reports frames that were genuinely forced.
              if (edge_hit || timeout_hit) begin
                ram_wr_en   <= 1'b1;
                ram_wr_addr <= '0;
                ram_wr_data <= adc_data;
                auto_trig   <= !edge_hit;
                state       <= CAPTURE;
              end
            end
          end
          CAPTURE: begin
            if (adc_valid) begin
              ram_wr_en   <= 1'b1;
              ram_wr_addr <= ram_wr_addr + 9'd1;
              ram_wr_data <= adc_data;
              if (ram_wr_addr + 9'd1 == last_addr)
                state <= DONE;
            end
          end
          DONE: begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trigger_capture.sv
// Randomised and directed bench for trigger_capture. A transaction-level model
// predicts the registered outputs every cycle. Directed scenarios also check
// frame-level facts against hand-computed constants.
module tb_trigger_capture;

  localparam logic [15:0] AUTO_TIMEOUT = 16'd16;

  logic       clock = 1'b0;
  logic       rst_n;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic       sample_type;
  logic [7:0] trig_level;
  logic       trig_slope;
  logic       trig_auto;
  logic       arm;
  logic       abort;
  logic       ram_wr_en;
  logic [8:0] ram_wr_addr;
  logic [7:0] ram_wr_data;
  logic       frame_done;
  logic       busy;
  logic       auto_trig;

  trigger_capture #(.AUTO_TIMEOUT(AUTO_TIMEOUT)) dut (
    .clock(clock), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .sample_type(sample_type), .trig_level(trig_level), .trig_slope(trig_slope),
    .trig_auto(trig_auto), .arm(arm), .abort(abort),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .frame_done(frame_done), .busy(busy), .auto_trig(auto_trig)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int printed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (printed < 60) begin
        printed++;
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
    end
  endtask

  // Behavioural model: mode 0 idle, 1 armed, 2 capturing, 3 finishing.
  int   m_mode = 0, m_n = 200, m_nwr = 0, m_cnt = 0, m_prev = 0, m_d, m_lvl;
  bit   m_pv = 0, m_hit, m_tmo, started = 0;
  logic e_en = 0, e_done = 0, e_busy = 0, e_auto = 0;
  logic [8:0] e_addr = '0;
  logic [7:0] e_data = '0;

  // Frame statistics gathered from DUT outputs
  int   wr_cnt, done_cnt, gap_err, first_data, first_addr, last_addr, max_addr;
  bit   seen;

  task automatic clr_stats();
    wr_cnt = 0; done_cnt = 0; gap_err = 0; first_data = -1; first_addr = -1;
    last_addr = -1; max_addr = -1; seen = 0;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (started) begin
        chk("ram_wr_en", ram_wr_en, e_en);
        chk("ram_wr_addr", ram_wr_addr, e_addr);
        chk("ram_wr_data", ram_wr_data, e_data);
        chk("frame_done", frame_done, e_done);
        chk("busy", busy, e_busy);
        chk("auto_trig", auto_trig, e_auto);
      end
      started = 1;
      if (ram_wr_en === 1'b1) begin
        if (!seen) begin
          first_data = ram_wr_data; first_addr = ram_wr_addr; seen = 1;
        end else if (int'(ram_wr_addr) != last_addr + 1) begin
          gap_err++;
        end
        wr_cnt++;
        last_addr = ram_wr_addr;
        if (int'(ram_wr_addr) > max_addr) max_addr = ram_wr_addr;
      end
      if (frame_done === 1'b1) done_cnt++;

      // predict the outputs after the coming posedge from the current inputs
      e_en = 0; e_done = 0;
      if (!rst_n) begin
        m_mode = 0; m_pv = 0; m_cnt = 0; m_prev = 0; m_nwr = 0;
        e_addr = '0; e_data = '0; e_auto = 0;
      end else if (abort) begin
        m_mode = 0;
      end else begin
        case (m_mode)
          0: if (arm) begin
               m_mode = 1; m_n = sample_type ? 400 : 200;
               m_pv = 0; m_cnt = 0; e_auto = 0;
             end
          1: if (adc_valid) begin
               m_d = adc_data; m_lvl = trig_level;
               m_hit = m_pv && (trig_slope ? (m_prev < m_lvl && m_d >= m_lvl)
                                           : (m_prev > m_lvl && m_d <= m_lvl));
               m_tmo = trig_auto && (m_cnt == int'(AUTO_TIMEOUT) - 1);
               if (m_hit || m_tmo) begin
                 e_en = 1; e_addr = 0; e_data = adc_data; e_auto = !m_hit;
                 m_nwr = 1; m_mode = 2;
               end
               m_prev = m_d; m_pv = 1;
               if (m_cnt < 65535) m_cnt++;
             end
          2: if (adc_valid) begin
               e_en = 1; e_addr = 9'(m_nwr); e_data = adc_data;
               m_nwr++;
               if (m_nwr == m_n) m_mode = 3;
             end
          default: begin e_done = 1; m_mode = 0; end
        endcase
      end
      e_busy = (m_mode != 0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic a, input logic v, input logic [7:0] d);
    arm = a; adc_valid = v; adc_data = d;
    step();
  endtask

  // Feed random valid samples until frame_done is seen, bounded.
  task automatic finish_frame(input int limit, input int vdiv);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      drive(1'b0, ($urandom_range(vdiv - 1) == 0), 8'($urandom));
      if (frame_done === 1'b1) begin ok = 1; break; end
    end
    adc_valid = 0;
    chk("frame_timeout", ok, 1);
  endtask

  initial begin
    rst_n = 0; adc_data = 0; adc_valid = 0; sample_type = 0; trig_level = 0;
    trig_slope = 1; trig_auto = 0; arm = 0; abort = 0;
    clr_stats();
    repeat (3) step();
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_addr", ram_wr_addr, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    step();

    // Rising ramp, single frame: 120 is the first sample, 140 triggers.
    clr_stats();
    sample_type = 0; trig_slope = 1; trig_level = 128;
    begin
      bit ok = 0;
      for (int k = 0; k < 400; k++) begin
        drive(k == 0, 1'b1, 8'(100 + 20 * k));
        sample_type = 1;  // late change must not alter the latched length
        if (frame_done === 1'b1) begin ok = 1; break; end
      end
      chk("ramp_timeout", ok, 1);
    end
    adc_valid = 0; step();
    chk("ramp_first_data", first_data, 140);
    chk("ramp_writes", wr_cnt, 200);
    chk("ramp_last_addr", last_addr, 199);
    chk("ramp_done_cnt", done_cnt, 1);
    chk("ramp_busy", busy, 0);

    // Falling, double frame: 60 then 40 crosses 50.
    clr_stats();
    sample_type = 1; trig_slope = 0; trig_level = 50;
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b1, 8'd60);
    drive(1'b0, 1'b1, 8'd40);
    finish_frame(2000, 2);
    step();
    chk("fall_first_data", first_data, 40);
    chk("fall_writes", wr_cnt, 400);
    chk("fall_max_addr", max_addr, 399);
    chk("fall_gaps", gap_err, 0);

    // Auto mode: constant data triggers on the 16th valid sample.
    clr_stats();
    sample_type = 0; trig_slope = 1; trig_level = 128; trig_auto = 1;
    begin
      int at = -1;
      drive(1'b1, 1'b1, 8'd10);
      for (int i = 1; i <= 40; i++) begin
        drive(1'b0, 1'b1, 8'd10);
        if (ram_wr_en === 1'b1) begin at = i; break; end
      end
      chk("auto_sample_idx", at, 16);
      chk("auto_flag", auto_trig, 1);
    end
    finish_frame(2000, 1);
    step();
    chk("auto_writes", wr_cnt, 200);
    chk("auto_flag_held", auto_trig, 1);

    // Normal mode, no crossing: waits forever, abort returns to idle.
    clr_stats();
    trig_auto = 0;
    drive(1'b1, 1'b1, 8'd10);
    repeat (300) drive(1'b0, 1'b1, 8'd10);
    chk("stall_writes", wr_cnt, 0);
    chk("stall_busy", busy, 1);
    abort = 1; step(); abort = 0;
    chk("abort_busy", busy, 0);

    // Sparse valid during capture with arm pulses that must be ignored.
    clr_stats();
    begin
      bit ok = 0;
      for (int k = 0; k < 1500; k++) begin
        drive((k % 7) == 0, (k < 3) || (k % 3 == 0),
              (k == 1) ? 8'd100 : (k == 2) ? 8'd200 : 8'($urandom));
        if (frame_done === 1'b1) begin ok = 1; break; end
      end
      arm = 0; adc_valid = 0;
      chk("sparse_timeout", ok, 1);
    end
    step();
    chk("sparse_writes", wr_cnt, 200);
    chk("sparse_gaps", gap_err, 0);

    // Reset at address 57 discards the frame.
    clr_stats();
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b1, 8'd100);
    begin
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
        drive(1'b0, 1'b1, 8'd200);
        if (ram_wr_en === 1'b1 && ram_wr_addr == 9'd57) begin ok = 1; break; end
      end
      chk("addr57_reached", ok, 1);
    end
    rst_n = 0; step(); rst_n = 1;
    chk("rst57_en", ram_wr_en, 0);
    chk("rst57_addr", ram_wr_addr, 0);
    chk("rst57_busy", busy, 0);
    clr_stats();
    repeat (300) drive(1'b0, 1'b1, 8'($urandom));
    chk("rst57_writes", wr_cnt, 0);
    chk("rst57_done", done_cnt, 0);
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b1, 8'd100);
    drive(1'b0, 1'b1, 8'd200);
    finish_frame(2000, 1);
    step();
    chk("rearm_first_addr", first_addr, 0);
    chk("rearm_writes", wr_cnt, 200);

    // Random soak
    for (int i = 0; i < 20000; i++) begin
      rst_n       = ($urandom_range(2999) != 0);
      abort       = ($urandom_range(799) == 0);
      arm         = ($urandom_range(9) == 0);
      adc_valid   = $urandom_range(1);
      adc_data    = 8'($urandom);
      if ($urandom_range(99) == 0) begin
        sample_type = $urandom_range(1);
        trig_slope  = $urandom_range(1);
        trig_auto   = $urandom_range(1);
        trig_level  = 8'($urandom);
      end
      step();
    end
    rst_n = 1; abort = 0; arm = 0; adc_valid = 0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
